// File: rtl/dinl_pkg.sv
// Shared constants and state encoding for the DINL correction load path.
// Chains 0..R1_CHAIN_BASE-1 feed RITC half R0, the rest feed R1.
package dinl_pkg;

  localparam int NCHAINS       = 32;
  localparam int CHAIN_LEN     = 32;
  localparam int ADDR_BITS     = 5;
  localparam int R1_CHAIN_BASE = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } dinl_state_e;

endpackage

// File: rtl/dinl_column_buffer.sv
// Column staging RAM: one NCHAINS-wide column per address, registered read.
// The read register clears when not reading so the serial data idles at zero.
module dinl_column_buffer
  import dinl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [NCHAINS-1:0]   wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [NCHAINS-1:0]   rd_data_o
);

  logic [NCHAINS-1:0] mem_q [CHAIN_LEN];
  logic [NCHAINS-1:0] rd_data_q;

  // Storage is deliberately unreset so it maps onto distributed RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dinl_coeff_loader.sv
// DINL LUT chain loader: stages columns, waits for sync, then shifts all
// CHAIN_LEN columns out MSB-column-first on dinl_cdi/dinl_ce.
module dinl_coeff_loader
  import dinl_pkg::*;
(
  input  logic                 sysclk_i,
  input  logic                 rst_n_i,
  input  logic                 sync_i,
  input  logic                 wr_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [NCHAINS-1:0]   dat_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [NCHAINS-1:0]   dinl_cdi_o,
  output logic                 dinl_ce_o
);

  localparam logic [ADDR_BITS-1:0] PTR_LAST = ADDR_BITS'(CHAIN_LEN - 1);
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

  dinl_state_e          state_q, state_d;
  logic [ADDR_BITS-1:0] ptr_q, ptr_d;
  logic                 ce_q, ce_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 buf_wr;
  logic                 buf_rd;
  logic [NCHAINS-1:0]   buf_rd_data;

  dinl_column_buffer u_buf (
    .clk_i     (sysclk_i),
    .rst_n_i   (rst_n_i),
    .wr_en_i   (buf_wr),
    .wr_addr_i (addr_i),
    .wr_data_i (dat_i),
    .rd_en_i   (buf_rd),
    .rd_addr_i (ptr_q),
    .rd_data_o (buf_rd_data)
  );

  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ce_q    <= ce_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    buf_wr  = 1'b0;
    buf_rd  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        buf_wr = wr_i;
        if (start_i) begin
          state_d = ST_ARMED;
          err_d   = 1'b0;
        end
      end
      ST_ARMED: begin
        if (wr_i) begin
          err_d = 1'b1;
        end
        if (sync_i) begin
          state_d = ST_SHIFT;
          ptr_d   = PTR_LAST;
        end
      end
      ST_SHIFT: begin
        buf_rd = 1'b1;
        if (wr_i) begin
          err_d = 1'b1;
        end
        // Column 0 is the last one; stop there rather than wrapping.
        if (ptr_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ptr_d = ptr_q - PTR_ONE;
        end
      end
      ST_DONE: begin
        buf_wr  = wr_i;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything else issued in the same cycle.
    if (abort_i) begin
      state_d = ST_IDLE;
      ptr_d   = ptr_q;
      err_d   = err_q;
      buf_wr  = 1'b0;
      buf_rd  = 1'b0;
    end
  end

  // The buffer read lags the pointer by one cycle, so ce lags SHIFT equally.
  assign ce_d   = (state_q == ST_SHIFT) && !abort_i;
  assign done_d = (state_q == ST_DONE) && !abort_i;
  assign busy_d = (state_d != ST_IDLE);

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign dinl_ce_o  = ce_q;
  assign dinl_cdi_o = buf_rd_data;

endmodule

// File: tb/tb_dinl_coeff_loader.sv
// Self-checking bench for dinl_coeff_loader: scoreboard on the serial words,
// cycle-exact checks of ce/done/busy/err around each load.
module tb_dinl_coeff_loader;
  import dinl_pkg::*;

  logic                 sysclk_i;
  logic                 rst_n_i;
  logic                 sync_i;
  logic                 wr_i;
  logic [ADDR_BITS-1:0] addr_i;
  logic [NCHAINS-1:0]   dat_i;
  logic                 start_i;
  logic                 abort_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic [NCHAINS-1:0]   dinl_cdi_o;
  logic                 dinl_ce_o;

  int total = 0;
  int bad   = 0;
  logic [NCHAINS-1:0] exp_q[$];
  logic [NCHAINS-1:0] model_buf [CHAIN_LEN];
  bit mon_en = 1'b0;
  bit err_model = 1'b0;

  dinl_coeff_loader dut (
    .sysclk_i   (sysclk_i),
    .rst_n_i    (rst_n_i),
    .sync_i     (sync_i),
    .wr_i       (wr_i),
    .addr_i     (addr_i),
    .dat_i      (dat_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .dinl_cdi_o (dinl_cdi_o),
    .dinl_ce_o  (dinl_ce_o)
  );

  // clock / reset
  initial sysclk_i = 1'b0;
  always #5 sysclk_i = ~sysclk_i;

  // scoreboard: every ce cycle must carry the next expected column
  always @(negedge sysclk_i) begin
    if (mon_en && rst_n_i) begin
      total++;
      if (dinl_ce_o === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL cdi_unexpected: ce high with nothing expected, cdi=%h", dinl_cdi_o);
        end else begin
          logic [NCHAINS-1:0] e;
          e = exp_q.pop_front();
          if (dinl_cdi_o !== e) begin
            bad++;
            $display("FAIL cdi_word: got %h expected %h at %0t", dinl_cdi_o, e, $time);
          end
        end
      end else if (dinl_cdi_o !== '0 || dinl_ce_o !== 1'b0) begin
        bad++;
        $display("FAIL cdi_idle: ce=%b cdi=%h expected ce=0 cdi=0 at %0t", dinl_ce_o, dinl_cdi_o, $time);
      end
    end
  end

  // driver tasks
  task automatic cyc();
    @(negedge sysclk_i);
  endtask

  task automatic wr_col(input int a, input logic [NCHAINS-1:0] d);
    wr_i = 1'b1; addr_i = ADDR_BITS'(a); dat_i = d;
    cyc();
    wr_i = 1'b0;
    model_buf[a] = d;
  endtask

  task automatic do_start(input bit with_sync, input bit with_wr,
                          input int a, input logic [NCHAINS-1:0] d);
    start_i = 1'b1; sync_i = with_sync;
    if (with_wr) begin
      wr_i = 1'b1; addr_i = ADDR_BITS'(a); dat_i = d;
      model_buf[a] = d;
    end
    cyc();
    start_i = 1'b0; sync_i = 1'b0; wr_i = 1'b0;
    err_model = 1'b0;
    total++;
    if (busy_o !== 1'b1 || err_o !== 1'b0 || dinl_ce_o !== 1'b0) begin
      bad++;
      $display("FAIL start_ack: busy=%b err=%b ce=%b expected busy=1 err=0 ce=0", busy_o, err_o, dinl_ce_o);
    end
  endtask

  task automatic wait_armed(input int n);
    for (int k = 0; k < n; k++) begin
      cyc();
      total++;
      if (busy_o !== 1'b1 || dinl_ce_o !== 1'b0 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL armed_hold: busy=%b ce=%b done=%b expected busy=1 ce=0 done=0", busy_o, dinl_ce_o, done_o);
      end
    end
  endtask

  // Drives the sync that counts (cycle T) then checks cycles T+1..T+40.
  // abort_at/wr_at are cycle offsets from T (0 = not used).
  task automatic run_load(input int abort_at, input int wr_at);
    bit exp_ce, exp_done, exp_busy;
    for (int i = CHAIN_LEN - 1; i >= 0; i--) exp_q.push_back(model_buf[i]);
    sync_i = 1'b1;
    cyc();
    sync_i = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (abort_at == 0) begin
        exp_ce   = (j >= 2) && (j <= CHAIN_LEN + 1);
        exp_done = (j == CHAIN_LEN + 2);
        exp_busy = (j <= CHAIN_LEN + 1);
      end else begin
        exp_ce   = (j >= 2) && (j <= abort_at);
        exp_done = 1'b0;
        exp_busy = (j <= abort_at);
      end
      if (wr_at != 0 && j == wr_at + 1) err_model = 1'b1;
      total++;
      if (dinl_ce_o !== exp_ce || done_o !== exp_done || busy_o !== exp_busy || err_o !== err_model) begin
        bad++;
        $display("FAIL load_timing T+%0d: ce=%b done=%b busy=%b err=%b expected ce=%b done=%b busy=%b err=%b",
                 j, dinl_ce_o, done_o, busy_o, err_o, exp_ce, exp_done, exp_busy, err_model);
      end
      if (j == wr_at) begin
        wr_i = 1'b1; addr_i = ADDR_BITS'(7); dat_i = 32'hFFFF_0000;
      end
      if (j == abort_at) abort_i = 1'b1;
      cyc();
      wr_i = 1'b0; abort_i = 1'b0;
    end
    if (abort_at != 0) begin
      exp_q.delete();
    end else begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL load_count: %0d words not shifted, expected 0", exp_q.size());
        exp_q.delete();
      end
    end
  endtask

  // tests
  task automatic test_reset();
    rst_n_i = 1'b0; sync_i = 1'b0; wr_i = 1'b0; addr_i = '0; dat_i = '0;
    start_i = 1'b0; abort_i = 1'b0;
    repeat (3) cyc();
    total++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0 || dinl_ce_o !== 1'b0 || dinl_cdi_o !== '0) begin
      bad++;
      $display("FAIL reset_values: busy=%b done=%b err=%b ce=%b cdi=%h expected all 0",
               busy_o, done_o, err_o, dinl_ce_o, dinl_cdi_o);
    end
    rst_n_i = 1'b1;
    mon_en = 1'b1;
    // sync in IDLE must not start anything
    for (int k = 0; k < 4; k++) begin
      sync_i = k[0];
      cyc();
      total++;
      if (busy_o !== 1'b0 || dinl_ce_o !== 1'b0 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL idle_sync: busy=%b ce=%b done=%b expected 0 0 0", busy_o, dinl_ce_o, done_o);
      end
    end
    sync_i = 1'b0;
  endtask

  task automatic test_full_load();
    logic [NCHAINS-1:0] base;
    base = 32'h0101_0101;
    for (int i = 0; i < CHAIN_LEN; i++) wr_col(i, base << (i % 8));
    do_start(1'b0, 1'b0, 0, '0);
    wait_armed(4);
    run_load(0, 0);
  endtask

  task automatic test_early_sync();
    for (int i = 0; i < CHAIN_LEN; i++) wr_col(i, NCHAINS'($urandom()));
    do_start(1'b1, 1'b0, 0, '0);
    wait_armed(2);
    run_load(0, 0);
  endtask

  task automatic test_write_while_busy();
    do_start(1'b0, 1'b0, 0, '0);
    wait_armed(1);
    run_load(0, 5);
    do_start(1'b0, 1'b0, 0, '0);
    run_load(0, 0);
  endtask

  task automatic test_abort();
    do_start(1'b0, 1'b0, 0, '0);
    run_load(11, 0);
    do_start(1'b0, 1'b0, 0, '0);
    wait_armed($urandom_range(0, 3));
    run_load(0, 0);
  endtask

  task automatic test_write_start_same();
    do_start(1'b0, 1'b1, 31, 32'hDEAD_BEEF);
    run_load(0, 0);
  endtask

  task automatic test_reset_mid_shift();
    do_start(1'b0, 1'b0, 0, '0);
    for (int i = CHAIN_LEN - 1; i >= 0; i--) exp_q.push_back(model_buf[i]);
    sync_i = 1'b1;
    cyc();
    sync_i = 1'b0;
    repeat (6) cyc();
    #2 rst_n_i = 1'b0;
    #1;
    total++;
    if (dinl_ce_o !== 1'b0 || dinl_cdi_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ce=%b cdi=%h busy=%b done=%b err=%b expected all 0",
               dinl_ce_o, dinl_cdi_o, busy_o, done_o, err_o);
    end
    exp_q.delete();
    err_model = 1'b0;
    cyc();
    rst_n_i = 1'b1;
    cyc();
    do_start(1'b0, 1'b0, 0, '0);
    wait_armed(50);
    abort_i = 1'b1;
    cyc();
    abort_i = 1'b0;
    total++;
    if (busy_o !== 1'b0 || dinl_ce_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_armed: busy=%b ce=%b done=%b expected 0 0 0", busy_o, dinl_ce_o, done_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_early_sync();
    test_write_while_busy();
    test_abort();
    test_write_start_same();
    test_reset_mid_shift();
    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
